// File: rtl/arith_pkg.sv
// Shared constants and types for the small arithmetic datapath (subtractor, divider).
// Width is fixed at 4 bits throughout.
package arith_pkg;

    localparam int ARITH_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [ARITH_W-1:0] quo;
        logic [ARITH_W-1:0] rem;
        logic               dz;
    } div_res_t;

endpackage

// File: rtl/subtractor_4_bit.sv
// Combinational 4-bit subtractor: Z = X - Y - Bi, Bf is the borrow out of the MSB.
// Zero latency, no flow control.
module subtractor_4_bit
    import arith_pkg::*;
(
    input  logic [ARITH_W-1:0] X,
    input  logic [ARITH_W-1:0] Y,
    input  logic               Bi,
    output logic [ARITH_W-1:0] Z,
    output logic               Bf
);

    logic [ARITH_W:0] diff;

    // One extra bit catches the borrow as the sign of the widened difference.
    assign diff = {1'b0, X} - {1'b0, Y} - {{ARITH_W{1'b0}}, Bi};
    assign Z    = diff[ARITH_W-1:0];
    assign Bf   = diff[ARITH_W];

endmodule

// File: rtl/divider_4_bit.sv
// Sequential 4-bit unsigned restoring divider, one trial subtraction per clock.
// done follows the accepting edge by 4 clocks (1 for divide-by-zero); start is ignored while busy.
module divider_4_bit
    import arith_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ARITH_W-1:0] dividend,
    input  logic [ARITH_W-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [ARITH_W-1:0] quotient,
    output logic [ARITH_W-1:0] remainder,
    output logic               div_by_zero
);

    logic [1:0]         state_q, state_d;
    logic [ARITH_W-1:0] q_q, q_d;
    logic [ARITH_W-1:0] r_q, r_d;
    logic [ARITH_W-1:0] d_q, d_d;
    logic [1:0]         cnt_q, cnt_d;
    div_res_t           res_q, res_d;

    logic [ARITH_W:0]   s;
    logic [ARITH_W-1:0] z;
    logic               bf;
    logic               ok;
    logic [ARITH_W-1:0] r_next;
    logic [ARITH_W-1:0] q_next;

    // Shifted partial remainder; its 5th bit set means it already exceeds any 4-bit divisor.
    assign s = {r_q, q_q[ARITH_W-1]};

    subtractor_4_bit u_sub (
        .X  (s[ARITH_W-1:0]),
        .Y  (d_q),
        .Bi (1'b0),
        .Z  (z),
        .Bf (bf)
    );

    assign ok     = s[ARITH_W] | ~bf;
    assign r_next = ok ? z : s[ARITH_W-1:0];
    assign q_next = {q_q[ARITH_W-2:0], ok};

    always_comb begin
        state_d = ST_IDLE;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (state_q == ST_RUN) begin
            state_d = ST_RUN;
            r_d     = r_next;
            q_d     = q_next;
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                state_d = ST_DONE;
                res_d   = '{quo: q_next, rem: r_next, dz: 1'b0};
            end
        end else if (start) begin
            // IDLE and DONE both accept a new request, allowing back-to-back operations.
            if (divisor == '0) begin
                state_d = ST_DONE;
                res_d   = '{quo: {ARITH_W{1'b1}}, rem: dividend, dz: 1'b1};
            end else begin
                state_d = ST_RUN;
                q_d     = dividend;
                d_d     = divisor;
                r_d     = '0;
                cnt_d   = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = res_q.quo;
    assign remainder   = res_q.rem;
    assign div_by_zero = res_q.dz;

endmodule

// File: tb/tb_divider_4_bit.sv
// Scoreboard bench for divider_4_bit: expected results queued at start, compared on done.
module tb_divider_4_bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    divider_4_bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t ref_div(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q  = 4'hF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = 4'(int'(a) / int'(b));
            e.r  = 4'(int'(a) % int'(b));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            end
        end
    end

    // Pulse start for one cycle, then wait for done, checking latency and busy duration.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        int lat;
        int busy_cyc;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(ref_div(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat      = 1;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), (b == 4'd0) ? 32'd1 : 32'd5);
        chk("busy_cycles", 32'(busy_cyc), (b == 4'd0) ? 32'd0 : 32'd4);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_quo"}, 32'(quotient), 32'd0);
        chk({tag, "_rem"}, 32'(remainder), 32'd0);
        chk({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        #1;
        chk_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd13, 4'd3);
        run_op(4'd15, 4'd1);
        run_op(4'd0, 4'd5);
        run_op(4'd7, 4'd9);
        run_op(4'd6, 4'd0);

        // Start while RUN is ignored; start in the DONE cycle is accepted.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        exp_q.push_back(ref_div(4'd13, 4'd3));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        exp_q.push_back(ref_div(4'd9, 4'd2));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();
        repeat (6) @(negedge clk);
        chk("queue_drained_b2b", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-operation, on the second RUN cycle.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        repeat (6) @(negedge clk);
        chk("rst_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(4'd14, 4'd4);

        // Results are held with start low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd0);
            chk("hold_quo", 32'(quotient), 32'd3);
            chk("hold_rem", 32'(remainder), 32'd2);
            chk("hold_dz", 32'(div_by_zero), 32'd0);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
